hex_disp_feeder: RTL and testbench
==================================

HEX_DISP_FEEDER -- requirements
Module: hex_disp_feeder

Interface
REQ-001 Parameter N, default 29: refresh counter width; must match the display multiplexer's N.
REQ-002 Parameter B, default 27: blink counter width; blink phase is bit B-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  upstream offers load_data, dp and blank_lz.
REQ-006 load_ready  output  1  block can accept a load this cycle.
REQ-007 load_data  input  16  four hex digits; [15:12] maps to in3 and [3:0] maps to in0.
REQ-008 dp  input  4  decimal-point request per digit; bit i maps to in_i; active-high.
REQ-009 blank_lz  input  1  leading-zero blanking enable.
REQ-010 blink_en  input  4  per-digit blink enable; live, not latched.
REQ-011 in3, in2, in1, in0  output  8 each  segment patterns, active-low, bit7=dp, bits6:0={g,f,e,d,c,b,a}.
REQ-012 counter  output  N  free-running refresh count for the display multiplexer.

Function
REQ-013 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; the block samples load_data, dp and blank_lz at that edge (E0).
REQ-014 load_ready SHALL be 1 only in state IDLE; load_valid while busy SHALL be ignored, and upstream holds valid and data until accepted.
REQ-015 FSM states SHALL be IDLE and CONV; transitions: IDLE->CONV on accept; CONV stays for 4 cycles, digit index 3,2,1,0; CONV->IDLE after index 0.
REQ-016 Each CONV cycle SHALL encode one digit (index 3 first) into a shadow register via the hex-to-segment table; dp bit7 = ~dp[i].
REQ-017 Leading-zero blanking: with blank_lz=1, digit i (i>=1) SHALL be 8'hFF (dp included) if it and all higher digits are 0; digit 0 is never blanked.
REQ-018 Display registers SHALL update atomically from the shadow register at edge E4; new values are visible after E4, and no partial update is ever visible.
REQ-019 load_ready SHALL return to 1 after E4; the earliest next accept is E5, so throughput is 1 load per 5 cycles.
REQ-020 Outputs: in_i = 8'hFF when blink_en[i]=1 and blink phase=1, else the display register i; this masking is combinational from registered state.
REQ-021 counter SHALL increment by 1 every cycle and wrap from 2^N-1 to 0; it is unaffected by loads.
REQ-022 The blink counter (B bits) SHALL increment every cycle and wrap from 2^B-1 to 0.
REQ-023 Segment table (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-024 While rst=0: state=IDLE, load_ready=1, display and shadow registers=8'hFF, counter=0, blink counter=0.
REQ-025 Reset asserted mid-CONV SHALL abort the conversion; the partial shadow contents SHALL never reach the outputs.
REQ-026 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 Package disp_pkg SHALL hold the state enum, the SEG_BLANK=8'hFF constant and the 16-entry segment table.
REQ-028 One combinational sub-module hex_to_sseg SHALL map 4-bit hex to 7-bit pattern; there is one instance, shared across CONV cycles.

Verification
REQ-029 Load 16'h00A5, blank_lz=1, dp=0 -> after E4: in3=FF, in2=FF, in1=88, in0=92; load_ready=0 from E0 to E4.
REQ-030 Load 16'h0000, blank_lz=1 -> in3..in1=FF, in0=C0; with blank_lz=0 -> all four digits=C0.
REQ-031 Load 16'h1234, blank_lz=0, dp=4'b0100 -> in3=F9, in2=24, in1=B0, in0=99.
REQ-032 Hold load_valid=1 continuously with changing data -> accepts only at E0, E5, E10; outputs never show a mixed-digit value.
REQ-033 N=4, B=3, blink_en=4'b0001 after loading 16'h1234 -> counter sequence 15->0; in0 alternates 99/FF every 4 cycles; in3..in1 steady.
REQ-034 Assert rst at E2 of a load of 16'hFFFF -> all outputs FF, counter=0, load_ready=1; the load is never displayed.

Source files
------------

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : disp_pkg
// Brief    : Shared FSM state type and seven-segment constants for the feeder.
// Revision : 1.0
// ============================================================================
package disp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the least significant slice.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage
`default_nettype wire

// File: rtl/hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_sseg
// Brief    : Combinational hex nibble to active-low seven-segment pattern.
// Revision : 1.0
// ============================================================================
module hex_to_sseg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] sseg
);

    assign sseg = SEG_TABLE[hex];

endmodule
`default_nettype wire

// File: rtl/hex_disp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : hex_disp_feeder
// Brief    : Accepts a 4-digit hex word, encodes one digit per cycle into a
//            shadow bank, then publishes all four digits in a single edge.
// Revision : 1.0
// ============================================================================
module hex_disp_feeder
    import disp_pkg::*;
#(
    parameter int N = 29,
    parameter int B = 27
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [15:0]  load_data,
    input  logic [3:0]   dp,
    input  logic         blank_lz,
    input  logic [3:0]   blink_en,
    output logic [7:0]   in3,
    output logic [7:0]   in2,
    output logic [7:0]   in1,
    output logic [7:0]   in0,
    output logic [N-1:0] counter
);

    state_t       state;
    logic         ready_q;
    logic [1:0]   idx;
    logic [15:0]  data_q;
    logic [3:0]   dp_q;
    logic         blank_q;
    logic         higher_zero;
    logic [7:0]   shadow3;
    logic [7:0]   shadow2;
    logic [7:0]   shadow1;
    logic [7:0]   disp3;
    logic [7:0]   disp2;
    logic [7:0]   disp1;
    logic [7:0]   disp0;
    logic [B-1:0] blink_cnt;

    logic [3:0]   cur_hex;
    logic [6:0]   cur_seg;
    logic         cur_zero;
    logic         cur_blank;
    logic [7:0]   cur_code;
    logic         blink_phase;

    always_comb begin
        cur_hex = data_q[3:0];
        case (idx)
            2'd3:    cur_hex = data_q[15:12];
            2'd2:    cur_hex = data_q[11:8];
            2'd1:    cur_hex = data_q[7:4];
            default: cur_hex = data_q[3:0];
        endcase
    end

    hex_to_sseg u_hex_to_sseg (
        .hex  (cur_hex),
        .sseg (cur_seg)
    );

    // Digit 0 is never blanked so a value of zero still shows a single "0".
    assign cur_zero  = (cur_hex == 4'h0);
    assign cur_blank = blank_q && (idx != 2'd0) && cur_zero && higher_zero;
    assign cur_code  = cur_blank ? SEG_BLANK : {~dp_q[idx], cur_seg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            idx         <= 2'd3;
            data_q      <= '0;
            dp_q        <= '0;
            blank_q     <= 1'b0;
            higher_zero <= 1'b1;
            shadow3     <= SEG_BLANK;
            shadow2     <= SEG_BLANK;
            shadow1     <= SEG_BLANK;
            disp3       <= SEG_BLANK;
            disp2       <= SEG_BLANK;
            disp1       <= SEG_BLANK;
            disp0       <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state       <= CONV;
                        ready_q     <= 1'b0;
                        idx         <= 2'd3;
                        data_q      <= load_data;
                        dp_q        <= dp;
                        blank_q     <= blank_lz;
                        higher_zero <= 1'b1;
                    end
                end
                CONV: begin
                    higher_zero <= higher_zero & cur_zero;
                    case (idx)
                        2'd3: shadow3 <= cur_code;
                        2'd2: shadow2 <= cur_code;
                        2'd1: shadow1 <= cur_code;
                        default: begin
                            // Last digit bypasses the shadow so all four land together.
                            disp3   <= shadow3;
                            disp2   <= shadow2;
                            disp1   <= shadow1;
                            disp0   <= cur_code;
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    endcase
                    if (idx != 2'd0) begin
                        idx <= idx - 2'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter   <= '0;
            blink_cnt <= '0;
        end else begin
            counter   <= counter + N'(1);
            blink_cnt <= blink_cnt + B'(1);
        end
    end

    assign load_ready  = ready_q;
    assign blink_phase = blink_cnt[B-1];

    assign in3 = (blink_en[3] && blink_phase) ? SEG_BLANK : disp3;
    assign in2 = (blink_en[2] && blink_phase) ? SEG_BLANK : disp2;
    assign in1 = (blink_en[1] && blink_phase) ? SEG_BLANK : disp1;
    assign in0 = (blink_en[0] && blink_phase) ? SEG_BLANK : disp0;

endmodule
`default_nettype wire

// File: tb/tb_hex_disp_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_disp_feeder
// Brief    : Directed, table-driven bench for hex_disp_feeder (N=4, B=3).
// Revision : 1.0
// ============================================================================
module tb_hex_disp_feeder;

    localparam int N = 4;
    localparam int B = 3;

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         load_valid = 1'b0;
    logic [15:0]  load_data  = '0;
    logic [3:0]   dp         = '0;
    logic         blank_lz   = 1'b0;
    logic [3:0]   blink_en   = '0;
    logic         load_ready;
    logic [7:0]   in3, in2, in1, in0;
    logic [N-1:0] counter;

    int          checks = 0;
    int          errors = 0;
    int unsigned model_cnt = 0;
    logic [31:0] shown = 32'hFFFF_FFFF;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic        blank;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    hex_disp_feeder #(.N(N), .B(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .in3        (in3),
        .in2        (in2),
        .in1        (in1),
        .in0        (in0),
        .counter    (counter)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) model_cnt <= 0;
        else      model_cnt <= model_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] encode(input logic [15:0] d, input logic [3:0] p, input logic bl);
        logic [31:0] r;
        logic        hz;
        logic [3:0]  nib;
        r  = '0;
        hz = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            nib = d[i*4 +: 4];
            hz  = hz & (nib == 4'h0);
            if (bl && i > 0 && hz) r[i*8 +: 8] = 8'hFF;
            else                   r[i*8 +: 8] = {~p[i], seg7(nib)};
        end
        return r;
    endfunction

    function automatic logic [15:0] sdata(input int k);
        logic [3:0] a, b, c, d;
        a = 4'(k + 1);
        b = 4'(k + 3);
        c = 4'(k + 6);
        d = 4'(k + 10);
        return {a, b, c, d};
    endfunction

    // Offers v between edges; returns at the falling edge after E4.
    task automatic apply_load(input vec_t v, input string name);
        load_valid = 1'b1;
        load_data  = v.data;
        dp         = v.dpv;
        blank_lz   = v.blank;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = ~v.data;
        dp         = ~v.dpv;
        blank_lz   = ~v.blank;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check({name, "_busy_ready"}, {31'd0, load_ready}, 32'd0);
            check({name, "_busy_hold"}, {in3, in2, in1, in0}, shown);
            @(posedge clk);
        end
        @(negedge clk);
        check({name, "_ready"}, {31'd0, load_ready}, 32'd1);
        check({name, "_digits"}, {in3, in2, in1, in0}, v.exp);
        check({name, "_counter"}, {28'd0, counter}, {28'd0, model_cnt[3:0]});
        shown = v.exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vb;
        logic saw_wrap;
        logic [N-1:0] last_cnt;
        int src;

        vecs[0]  = '{16'h00A5, 4'b0000, 1'b1, 32'hFFFF_8892};
        vecs[1]  = '{16'h0000, 4'b0000, 1'b1, 32'hFFFF_FFC0};
        vecs[2]  = '{16'h0000, 4'b0000, 1'b0, 32'hC0C0_C0C0};
        vecs[3]  = '{16'h1234, 4'b0100, 1'b0, 32'hF924_B099};
        vecs[4]  = '{16'h0105, 4'b0000, 1'b1, 32'hFFF9_C092};
        vecs[5]  = '{16'h00F0, 4'b1111, 1'b1, 32'hFFFF_0E40};
        vecs[6]  = '{16'h0000, 4'b1111, 1'b1, 32'hFFFF_FF40};
        vecs[7]  = '{16'hABCD, 4'b0000, 1'b0, 32'h8883_C6A1};
        vecs[8]  = '{16'h6789, 4'b0000, 1'b0, 32'h82F8_8090};
        vecs[9]  = '{16'h00E0, 4'b1000, 1'b0, 32'h40C0_86C0};
        vecs[10] = '{16'h8000, 4'b0001, 1'b1, 32'h80C0_C040};

        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", {in3, in2, in1, in0}, 32'hFFFF_FFFF);
        check("reset_ready", {31'd0, load_ready}, 32'd1);
        check("reset_counter", {28'd0, counter}, 32'd0);

        // First accept lands on the very first edge after release.
        rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            apply_load(vecs[i], $sformatf("vec%0d", i));
        end

        // Valid held high with data changing every cycle.
        load_valid = 1'b1;
        load_data  = sdata(0);
        dp         = 4'b0000;
        blank_lz   = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            load_data = sdata(k + 1);
            @(negedge clk);
            check($sformatf("stream_ready_e%0d", k), {31'd0, load_ready}, (k % 5 == 4) ? 32'd1 : 32'd0);
            if (k >= 4) begin
                src = ((k - 4) / 5) * 5;
                check($sformatf("stream_digits_e%0d", k), {in3, in2, in1, in0}, encode(sdata(src), 4'b0000, 1'b0));
            end else begin
                check($sformatf("stream_digits_e%0d", k), {in3, in2, in1, in0}, shown);
            end
        end
        load_valid = 1'b0;
        shown = encode(sdata(10), 4'b0000, 1'b0);

        // Blink on digit 0, then on the upper three digits.
        vb = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4_B099};
        apply_load(vb, "blink_load");
        blink_en = 4'b0001;
        saw_wrap = 1'b0;
        last_cnt = counter;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("blink_counter", {28'd0, counter}, {28'd0, model_cnt[3:0]});
            check("blink_in0", {24'd0, in0}, model_cnt[2] ? 32'hFF : 32'h99);
            check("blink_upper", {8'd0, in3, in2, in1}, 32'h00F9_A4B0);
            if (last_cnt == 4'hF && counter == 4'h0) saw_wrap = 1'b1;
            last_cnt = counter;
        end
        check("counter_wrap_seen", {31'd0, saw_wrap}, 32'd1);
        blink_en = 4'b1110;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("blink_hi_digits", {in3, in2, in1, in0},
                  model_cnt[2] ? 32'hFFFF_FF99 : 32'hF9A4_B099);
        end
        blink_en = 4'b0000;

        // Reset partway through converting FFFF.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'hFFFF;
        dp         = 4'b0000;
        blank_lz   = 1'b0;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midconv_rst_digits", {in3, in2, in1, in0}, 32'hFFFF_FFFF);
        check("midconv_rst_counter", {28'd0, counter}, 32'd0);
        check("midconv_rst_ready", {31'd0, load_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("after_rst_digits", {in3, in2, in1, in0}, 32'hFFFF_FFFF);
            check("after_rst_ready", {31'd0, load_ready}, 32'd1);
        end
        check("after_rst_counter", {28'd0, counter}, {28'd0, model_cnt[3:0]});
        shown = 32'hFFFF_FFFF;
        apply_load(vecs[0], "recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
